// File: rtl/clock_ratio_pkg.sv
// Shared types for the clock ratio detector.
// FSM states, ratio codes and the period-to-ratio map.
package clock_ratio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    TRACK,
    LOCK
  } state_t;

  localparam logic [2:0] RATIO_UNKNOWN = 3'd0;
  localparam logic [2:0] RATIO_DIV2    = 3'd1;
  localparam logic [2:0] RATIO_DIV4    = 3'd2;
  localparam logic [2:0] RATIO_DIV8    = 3'd3;
  localparam logic [2:0] RATIO_DIV16   = 3'd4;

  function automatic logic [2:0] ratio_of(
    input logic [31:0] p
  );
    logic [2:0] r;
    r = RATIO_UNKNOWN;
    unique case (1'b1)
      (p == 32'd2):  r = RATIO_DIV2;
      (p == 32'd4):  r = RATIO_DIV4;
      (p == 32'd8):  r = RATIO_DIV8;
      (p == 32'd16): r = RATIO_DIV16;
      default:       r = RATIO_UNKNOWN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clock_ratio_detector_sync.sv
// 2-flop synchronizer plus edge flop, rising-edge pulse out.
// Ports: CLK, RESET (async high), i_sig, o_rise.
module sync_rise_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic i_sig,
  output logic o_rise
);

  // [0]=sync1, [1]=sync2, [2]=delayed sync2
  logic [2:0] r_sh;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sh <= '0;
    end else begin
      r_sh <= {r_sh[1:0], i_sig};
    end
  end

  assign o_rise = r_sh[1] & ~r_sh[2];

endmodule

// File: rtl/clock_ratio_detector.sv
// Measures SIG_IN period in CLK cycles, classifies ratio, flags lock/timeout.
// Ports: CLK, RESET, ENABLE, SIG_IN in; PERIOD, RATIO_CODE, VALID, LOCKED, TIMEOUT out.
module clock_ratio_detector
  import clock_ratio_pkg::*;
#(
  parameter  int MAX_PERIOD = 64,
  parameter  int LOCK_COUNT = 4,
  localparam int CW         = $clog2(MAX_PERIOD + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ENABLE,
  input  logic          SIG_IN,
  output logic [CW-1:0] PERIOD,
  output logic [2:0]    RATIO_CODE,
  output logic          VALID,
  output logic          LOCKED,
  output logic          TIMEOUT
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_PERIOD);
  localparam logic [MW-1:0] LC   = MW'(LOCK_COUNT);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [MW-1:0] r_mc;
  logic [CW-1:0] r_period;
  logic [2:0]    r_ratio;
  logic          r_valid;
  logic          r_locked;
  logic          r_timeout;

  logic          w_rise;
  logic [CW-1:0] w_meas;
  logic          w_match;
  logic [MW-1:0] w_mc_inc;
  logic [MW-1:0] w_mc_next;
  logic          w_tmo;

  sync_rise_detect u_sync (
    .CLK    (CLK),
    .RESET  (RESET),
    .i_sig  (SIG_IN),
    .o_rise (w_rise)
  );

  // An edge landing on the saturated count still reports MAX_PERIOD.
  assign w_meas    = (r_cnt == MAXC) ? MAXC : r_cnt + 1'b1;
  assign w_match   = (w_meas == r_period);
  assign w_mc_inc  = (r_mc == LC) ? LC : r_mc + 1'b1;
  assign w_mc_next = w_match ? w_mc_inc : MW'(1);
  assign w_tmo     = (r_cnt == MAXC) && !w_rise;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mc      <= '0;
      r_period  <= '0;
      r_ratio   <= RATIO_UNKNOWN;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!ENABLE) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_mc      <= '0;
        r_locked  <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        if (r_state == IDLE || w_rise) begin
          r_cnt <= '0;
        end else if (r_cnt != MAXC) begin
          r_cnt <= r_cnt + 1'b1;
        end
        unique case (r_state)
          IDLE: r_state <= ARM;
          ARM: begin
            if (w_rise) begin
              r_state <= TRACK;
            end else if (w_tmo) begin
              r_timeout <= 1'b1;
              r_locked  <= 1'b0;
              r_mc      <= '0;
            end
          end
          TRACK, LOCK: begin
            if (w_rise) begin
              r_valid   <= 1'b1;
              r_period  <= w_meas;
              r_ratio   <= ratio_of(32'(w_meas));
              r_timeout <= 1'b0;
              r_mc      <= w_mc_next;
              if (w_mc_next == LC) begin
                r_state  <= LOCK;
                r_locked <= 1'b1;
              end else begin
                r_state  <= TRACK;
                r_locked <= 1'b0;
              end
            end else if (w_tmo) begin
              r_state   <= ARM;
              r_timeout <= 1'b1;
              r_locked  <= 1'b0;
              r_mc      <= '0;
            end
          end
        endcase
      end
    end
  end

  assign PERIOD     = r_period;
  assign RATIO_CODE = r_ratio;
  assign VALID      = r_valid;
  assign LOCKED     = r_locked;
  assign TIMEOUT    = r_timeout;

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Bench for clock_ratio_detector.
// Scoreboard of expected measurements, popped on VALID.
module tb_clock_ratio_detector;

  localparam int CW = 7;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          ENABLE;
  logic          SIG_IN;
  logic [CW-1:0] PERIOD;
  logic [2:0]    RATIO_CODE;
  logic          VALID;
  logic          LOCKED;
  logic          TIMEOUT;

  clock_ratio_detector dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .SIG_IN     (SIG_IN),
    .PERIOD     (PERIOD),
    .RATIO_CODE (RATIO_CODE),
    .VALID      (VALID),
    .LOCKED     (LOCKED),
    .TIMEOUT    (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int p;
    int r;
    int lk;
    int vc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   last_rise = 0;
  bit   arm = 1'b1;
  int   prev_p = 0;
  int   mc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ratio(input int p);
    case (p)
      2:       return 1;
      4:       return 2;
      8:       return 3;
      16:      return 4;
      default: return 0;
    endcase
  endfunction

  // Reference: gap >= 66 means a timeout fired before this edge.
  task automatic rise_model();
    int g;
    int m;
    g = cyc - last_rise;
    last_rise = cyc;
    if (g >= 66) begin
      mc  = 0;
      arm = 1'b1;
    end
    if (arm) begin
      arm = 1'b0;
    end else begin
      m  = (g > 64) ? 64 : g;
      mc = (m == prev_p) ? ((mc < 4) ? mc + 1 : 4) : 1;
      prev_p = m;
      q.push_back('{m, ratio(m), (mc == 4) ? 1 : 0, cyc + 3});
    end
  endtask

  task automatic pulse_train(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      SIG_IN = 1'b1;
      rise_model();
      repeat (p / 2) @(negedge CLK);
      SIG_IN = 1'b0;
      repeat (p - p / 2) @(negedge CLK);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET && VALID) begin
      if (q.size() == 0) begin
        chk("valid_without_expect", q.size(), 1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("period", PERIOD, e.p);
        chk("ratio", RATIO_CODE, e.r);
        chk("locked", LOCKED, e.lk);
        chk("timeout_on_valid", TIMEOUT, 0);
        chk("valid_cycle", cyc, e.vc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    RESET  = 1'b1;
    ENABLE = 1'b0;
    SIG_IN = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_period", PERIOD, 0);
    chk("rst_ratio", RATIO_CODE, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_locked", LOCKED, 0);
    chk("rst_timeout", TIMEOUT, 0);
    RESET = 1'b0;
    @(negedge CLK);
    ENABLE = 1'b1;
    arm = 1'b1;
    repeat (3) @(negedge CLK);

    pulse_train(2, 8);
    chk("div2_locked", LOCKED, 1);

    pulse_train(16, 6);
    chk("div16_locked", LOCKED, 1);
    chk("div16_ratio", RATIO_CODE, 4);

    pulse_train(8, 6);
    chk("div8_locked", LOCKED, 1);
    pulse_train(4, 6);
    chk("div4_relocked", LOCKED, 1);

    pulse_train(16, 6);
    k = 0;
    while (!TIMEOUT && k < 100) begin
      @(negedge CLK);
      k++;
    end
    chk("timeout_seen", TIMEOUT, 1);
    chk("timeout_cycle", cyc - last_rise, 68);
    chk("timeout_locked", LOCKED, 0);
    chk("timeout_period_hold", PERIOD, 16);
    pulse_train(2, 6);
    chk("timeout_cleared", TIMEOUT, 0);

    pulse_train(64, 3);
    chk("p64_no_timeout", TIMEOUT, 0);
    chk("p64_period", PERIOD, 64);
    pulse_train(6, 3);
    chk("p6_ratio", RATIO_CODE, 0);

    pulse_train(4, 6);
    chk("pre_disable_locked", LOCKED, 1);
    ENABLE = 1'b0;
    mc  = 0;
    arm = 1'b1;
    @(negedge CLK);
    chk("disable_locked", LOCKED, 0);
    chk("disable_period_hold", PERIOD, 4);
    chk("disable_ratio_hold", RATIO_CODE, 2);
    ENABLE = 1'b1;
    repeat (2) @(negedge CLK);

    pulse_train(2, 3);
    repeat (3) @(negedge CLK);
    chk("track_period", PERIOD, 2);
    chk("queue_drained", q.size(), 0);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_period", PERIOD, 0);
    chk("arst_ratio", RATIO_CODE, 0);
    chk("arst_valid", VALID, 0);
    chk("arst_locked", LOCKED, 0);
    chk("arst_timeout", TIMEOUT, 0);
    repeat (2) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/clock_ratio_detector.md
Name: clock_ratio_detector

Overview:
Receive-side companion to the clock frequency divider. It samples one divided-clock signal with the master clock and measures its period in CLK cycles. It classifies the period as a divide ratio (2/4/8/16) and declares lock after repeated identical periods. It sits next to divider consumers as a self-check and status monitor for generated clocks.

Parameters:
MAX_PERIOD, 64, longest period accepted (CLK cycles); longer gaps raise TIMEOUT
LOCK_COUNT, 4, number of consecutive identical periods required to assert LOCKED
CW, $clog2(MAX_PERIOD+1), width of period counter and PERIOD output (derived; do not override)

Ports:
CLK  input  1  master clock; all state updates on posedge
RESET  input  1  async, active-high; clears all state
ENABLE  input  1  measurement enable; low forces IDLE
SIG_IN  input  1  divided clock under test; may be asynchronous to the posedge domain
PERIOD  output  CW  last measured period in CLK cycles (rising edge to rising edge)
RATIO_CODE  output  3  0=unknown, 1=div2, 2=div4, 3=div8, 4=div16
VALID  output  1  one-cycle pulse when PERIOD/RATIO_CODE update
LOCKED  output  1  high while LOCK_COUNT+ consecutive equal periods have been seen
TIMEOUT  output  1  sticky; no SIG_IN rising edge within MAX_PERIOD cycles

Behaviour:
- Reset: RESET is asynchronous, active-high. PERIOD=0, RATIO_CODE=0, VALID=0, LOCKED=0, TIMEOUT=0, FSM=IDLE, counters and sync flops=0.
- Input path: 2-flop synchronizer on SIG_IN, then a third flop. Rising edge = sync2 & ~sync3.
- Latency: VALID rises 2 CLK cycles after the first posedge that samples SIG_IN=1.
- Period counter cnt: cleared to 0 in an edge cycle, else increments. Measured value = cnt+1. Example: edges 2 cycles apart measure 2.
- FSM states:
  - IDLE: entered on reset or ENABLE=0. Goes to ARM when ENABLE=1.
  - ARM: waits for the first edge. That edge clears cnt without producing a measurement, then goes to TRACK.
  - TRACK: each edge produces a measurement (VALID pulse, PERIOD, RATIO_CODE).
    - Equal to the previous measurement: match_cnt+1.
    - Otherwise: match_cnt=1, LOCKED=0.
    - When match_cnt reaches LOCK_COUNT, go to LOCK and assert LOCKED in the same cycle as that VALID.
  - LOCK: each edge still produces a measurement.
    - Mismatch: LOCKED=0, match_cnt=1, go to TRACK.
- Timeout: in ARM, TRACK or LOCK, when cnt==MAX_PERIOD and there is no edge:
  - TIMEOUT=1, LOCKED=0, match_cnt=0, go to ARM.
  - PERIOD and RATIO_CODE hold.
  - TIMEOUT clears on the next VALID or when ENABLE=0.
- Simultaneous events: an edge in the cycle where cnt==MAX_PERIOD is a valid measurement of MAX_PERIOD with no timeout (edge wins). ENABLE=0 has priority over edge and timeout.
- ENABLE=0 mid-operation: next cycle FSM=IDLE. LOCKED, TIMEOUT, VALID, cnt and match_cnt clear. PERIOD and RATIO_CODE hold.
- RATIO_CODE is computed from the measured value and registered with PERIOD: 2->1, 4->2, 8->3, 16->4, anything else->0.
- Counters never wrap: cnt stops at MAX_PERIOD; match_cnt saturates at LOCK_COUNT.

Decomposition:
- Package clock_ratio_pkg: FSM state enum (IDLE, ARM, TRACK, LOCK) and RATIO_CODE constants (RATIO_UNKNOWN=0 … RATIO_DIV16=4).
- One sub-module, sync_rise_detect: 2-flop synchronizer plus edge flop, async RESET, output rise pulse.

Test Plan:
- Div-by-2 source: SIG_IN from a free-running divider, ENABLE=1. Required: first VALID shows PERIOD=2, RATIO_CODE=1; LOCKED=1 on the 4th VALID.
- Div-by-16 source: required PERIOD=16, RATIO_CODE=4, VALID pulses every 16 cycles, LOCKED after 4 measurements.
- Ratio switch: lock at div8, then switch the source to div4. Required: the first div4 measurement gives PERIOD=4, RATIO_CODE=2, LOCKED=0 in the same cycle; relock after 4 div4 periods.
- Stopped clock: lock at div16, then hold SIG_IN low. Required: TIMEOUT=1 and LOCKED=0 when cnt reaches 64; PERIOD stays 16. Restart div2: TIMEOUT clears on the first VALID.
- Boundary and unknown: a period of exactly 64 gives VALID with PERIOD=64 and no TIMEOUT; a period of 6 gives RATIO_CODE=0.
- Reset/enable abort: assert RESET mid-TRACK; all outputs go to 0 asynchronously. Drop ENABLE while locked: LOCKED=0 next cycle and PERIOD holds.
